poly_eval_gf32: RTL and testbench
=================================

POLY_EVAL_GF32 -- requirements
Module: poly_eval_gf32

Interface
REQ-001 SHALL have parameter M, default 230: number of GF256 coefficients (polynomial degree M-1).
REQ-002 SHALL have parameter T, default 3: number of GF(2^32) evaluation points.
REQ-003 SHALL have port i_clk  in  1  clock; reset i_rst, synchronous, active-high; clock i_clk.
REQ-004 SHALL have port i_rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port i_start  in  1  single-cycle start request.
REQ-006 SHALL have port i_r  in  32*T  evaluation points; point j = i_r[32j+31:32j].
REQ-007 SHALL have port o_coef_addr  out  CLOG2(M)  coefficient read address.
REQ-008 SHALL have port o_coef_rd  out  1  coefficient read strobe; i_coef is valid exactly 1 cycle later.
REQ-009 SHALL have port i_coef  in  8  coefficient data.
REQ-010 SHALL have ports o_start_mul32 out 1, o_x_mul32 out 32, o_y_mul32 out 32, i_o_mul32 in 32, i_done_mul32 in 1: shared GF(2^32) multiplier handshake.
REQ-011 SHALL have port o_eval  out  32*T  results; slot j corresponds to point j.
REQ-012 SHALL have ports o_busy out 1 (high outside IDLE) and o_done out 1 (completion pulse).

Function
REQ-013 SHALL compute, per point j, P(r_j) = sum c_i * r_j^i via Horner evaluation, coefficients read from address M-1 down to 0.
REQ-014 SHALL zero-extend each coefficient to 32 bits; GF addition SHALL be bitwise XOR.
REQ-015 SHALL latch i_r into an internal register on the accepted i_start cycle; later i_r changes SHALL NOT affect the run.
REQ-016 SHALL use states IDLE, READ, LATCH, MUL_START, MUL_WAIT, ACC, NEXT, DONE.
REQ-017 IDLE: on i_start, clear all accumulators, set address M-1, go to READ.
REQ-018 READ: assert o_coef_rd for one cycle with the current address; go to LATCH.
REQ-019 LATCH: capture i_coef; set point index j=0; go to MUL_START.
REQ-020 MUL_START: pulse o_start_mul32 for exactly one cycle with o_x_mul32 = acc_j and o_y_mul32 = r_j; go to MUL_WAIT.
REQ-021 MUL_WAIT: hold operands stable; on i_done_mul32, write acc_j = i_o_mul32 XOR coef; go to ACC.
REQ-022 ACC: if j = T-1, go to NEXT; otherwise increment j and go to MUL_START.
REQ-023 NEXT: if address = 0, go to DONE; otherwise decrement the address and go to READ.
REQ-024 DONE: copy the accumulators to o_eval, pulse o_done for one cycle, and return to IDLE.
REQ-025 o_eval SHALL hold its value from DONE until the next DONE or reset.
REQ-026 i_start SHALL be ignored while o_busy is high.
REQ-027 i_start coincident with o_done SHALL be ignored; a new start is accepted only in IDLE.
REQ-028 Multiplier latency SHALL be arbitrary (1 or more cycles); an i_done_mul32 outside MUL_WAIT SHALL be ignored.

Reset
REQ-029 On i_rst, state SHALL be IDLE, and o_eval, accumulators, o_done, o_busy, o_coef_rd and o_start_mul32 SHALL be 0.
REQ-030 Reset during a run SHALL abort it within one cycle, with no o_done pulse.

Configuration
REQ-031 Macro POLY_EVAL_LEADING_SKIP_EN SHALL select leading-coefficient handling.
REQ-032 With the macro defined, the first coefficient (address M-1) SHALL be loaded directly into every acc_j without multiplication, giving (M-1)*T multiplies per run.
REQ-033 With the macro undefined, every coefficient SHALL go through REQ-020..022, giving M*T multiplies per run.
REQ-034 o_eval SHALL be identical in both builds.

Verification
REQ-035 T=3, M=2, c1=0x01, c0=0x05, all r_j=0x00000002, 1-cycle multiplier model -> every o_eval slot = 0x00000007, one o_done pulse.
REQ-036 M=230, all coefficients 0x00, random r -> o_eval = 0; o_start_mul32 pulse count = 690 without the macro, 687 with it.
REQ-037 Same polynomial and points run with multiplier latency 1 and latency 5 -> identical o_eval; o_coef_addr sequence 229..0 with one read each.
REQ-038 i_start pulsed mid-run and again on the o_done cycle -> no restart, a single o_done, o_eval unchanged by the extra pulses.
REQ-039 i_rst asserted while in MUL_WAIT -> next cycle IDLE with all outputs 0; a following start -> correct result.

Source files
------------

// File: rtl/poly_eval_gf32.sv
// Horner evaluation of a GF256-coefficient polynomial at T points in GF(2^32), sharing one external multiplier.
// Build option: define POLY_EVAL_LEADING_SKIP_EN to seed accumulators with the leading coefficient (saves T multiplies).
module poly_eval_gf32 #(
  parameter int M = 230,
  parameter int T = 3,
  localparam int AW = (M > 1) ? $clog2(M) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [32*T-1:0] i_r,
  output logic [AW-1:0]   o_coef_addr,
  output logic            o_coef_rd,
  input  logic [7:0]      i_coef,
  output logic            o_start_mul32,
  output logic [31:0]     o_x_mul32,
  output logic [31:0]     o_y_mul32,
  input  logic [31:0]     i_o_mul32,
  input  logic            i_done_mul32,
  output logic [32*T-1:0] o_eval,
  output logic            o_busy,
  output logic            o_done
);
  localparam int JW = (T > 1) ? $clog2(T) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] READ      = 3'd1;
  localparam logic [2:0] LATCH     = 3'd2;
  localparam logic [2:0] MUL_START = 3'd3;
  localparam logic [2:0] MUL_WAIT  = 3'd4;
  localparam logic [2:0] ACC       = 3'd5;
  localparam logic [2:0] NEXT      = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  logic [2:0]          state;
  logic [AW-1:0]       addr;
  logic [JW-1:0]       j;
  logic [7:0]          coef;
  logic [T-1:0][31:0]  acc;
  logic [T-1:0][31:0]  r_q;
  logic [T-1:0][31:0]  eval;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      addr  <= '0;
      j     <= '0;
      coef  <= '0;
      acc   <= '0;
      r_q   <= '0;
      eval  <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          acc   <= '0;
          addr  <= AW'(M - 1);
          r_q   <= i_r;
          state <= READ;
        end
        READ: state <= LATCH;
        LATCH: begin
          coef <= i_coef;
          j    <= '0;
`ifdef POLY_EVAL_LEADING_SKIP_EN
          // Leading coefficient: acc is still zero, so 0*r^c reduces to just c.
          if (addr == AW'(M - 1)) begin
            for (int t = 0; t < T; t++) acc[t] <= {24'h0, i_coef};
            state <= NEXT;
          end else begin
            state <= MUL_START;
          end
`else
          state <= MUL_START;
`endif
        end
        MUL_START: state <= MUL_WAIT;
        MUL_WAIT: if (i_done_mul32) begin
          acc[j] <= i_o_mul32 ^ {24'h0, coef};
          state  <= ACC;
        end
        ACC: if (j == JW'(T - 1)) begin
          state <= NEXT;
        end else begin
          j     <= j + 1'b1;
          state <= MUL_START;
        end
        NEXT: if (addr == '0) begin
          state <= DONE;
        end else begin
          addr  <= addr - 1'b1;
          state <= READ;
        end
        DONE: begin
          eval  <= acc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operands are muxed straight from registers, so they stay stable through MUL_WAIT.
  assign o_coef_addr   = addr;
  assign o_coef_rd     = (state == READ);
  assign o_start_mul32 = (state == MUL_START);
  assign o_x_mul32     = acc[j];
  assign o_y_mul32     = r_q[j];
  assign o_eval        = eval;
  assign o_busy        = (state != IDLE);
  assign o_done        = (state == DONE);
endmodule

// File: tb/tb_poly_eval_gf32.sv
// Directed bench: small M=2 instance for hand-checked cases, M=230 instance for sequencing and latency cases.
module tb_poly_eval_gf32;
  localparam int T = 3;
  localparam logic [31:0] POLY = 32'h0040_0007;

  integer checks = 0;
  integer errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: M=2
  logic            start_a = 1'b0;
  logic [32*T-1:0] r_a = '0;
  logic [0:0]      addr_a;
  logic            rd_a, smul_a, dn_a, busy_a, done_a;
  logic [7:0]      coef_a = '0;
  logic [31:0]     x_a, y_a, om_a;
  logic [32*T-1:0] eval_a;
  logic [7:0]      mem_a [0:1];

  // Instance B: M=230
  logic            start_b = 1'b0;
  logic [32*T-1:0] r_b = '0;
  logic [7:0]      addr_b;
  logic            rd_b, smul_b, dn_b, busy_b, done_b;
  logic [7:0]      coef_b = '0;
  logic [31:0]     x_b, y_b, om_b;
  logic [32*T-1:0] eval_b;
  logic [7:0]      mem_b [0:229];

  poly_eval_gf32 #(.M(2), .T(T)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_r(r_a),
    .o_coef_addr(addr_a), .o_coef_rd(rd_a), .i_coef(coef_a),
    .o_start_mul32(smul_a), .o_x_mul32(x_a), .o_y_mul32(y_a),
    .i_o_mul32(om_a), .i_done_mul32(dn_a),
    .o_eval(eval_a), .o_busy(busy_a), .o_done(done_a));

  poly_eval_gf32 #(.M(230), .T(T)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_r(r_b),
    .o_coef_addr(addr_b), .o_coef_rd(rd_b), .i_coef(coef_b),
    .o_start_mul32(smul_b), .o_x_mul32(x_b), .o_y_mul32(y_b),
    .i_o_mul32(om_b), .i_done_mul32(dn_b),
    .o_eval(eval_b), .o_busy(busy_b), .o_done(done_b));

  function automatic logic [31:0] gfmul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p = '0;
    logic [31:0] aa = a;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[31] ? ((aa << 1) ^ POLY) : (aa << 1);
    end
    return p;
  endfunction

  // Coefficient memories, read data one cycle after the strobe
  always @(posedge clk) if (rd_a) coef_a <= mem_a[addr_a];
  always @(posedge clk) if (rd_b) coef_b <= mem_b[addr_b];

  // Multiplier models with programmable latency and optional stray done pulses
  int   lat_a = 1, lat_b = 1, cnt_a = 0, cnt_b = 0;
  bit   stray_a = 0, stray_b = 0, pend_a = 0, pend_b = 0;
  logic [31:0] res_a = '0, res_b = '0;
  initial begin dn_a = 1'b0; dn_b = 1'b0; om_a = '0; om_b = '0; end

  always @(posedge clk) begin
    dn_a <= 1'b0;
    if (rst) pend_a <= 0;
    else if (pend_a) begin
      if (cnt_a <= 1) begin dn_a <= 1'b1; om_a <= res_a; pend_a <= 0; end
      else cnt_a <= cnt_a - 1;
    end else if (smul_a) begin
      if (lat_a == 1) begin dn_a <= 1'b1; om_a <= gfmul(x_a, y_a); end
      else begin pend_a <= 1; cnt_a <= lat_a - 1; res_a <= gfmul(x_a, y_a); end
    end else if (stray_a && $urandom_range(3) == 0) begin
      dn_a <= 1'b1; om_a <= $urandom;
    end
  end

  always @(posedge clk) begin
    dn_b <= 1'b0;
    if (rst) pend_b <= 0;
    else if (pend_b) begin
      if (cnt_b <= 1) begin dn_b <= 1'b1; om_b <= res_b; pend_b <= 0; end
      else cnt_b <= cnt_b - 1;
    end else if (smul_b) begin
      if (lat_b == 1) begin dn_b <= 1'b1; om_b <= gfmul(x_b, y_b); end
      else begin pend_b <= 1; cnt_b <= lat_b - 1; res_b <= gfmul(x_b, y_b); end
    end else if (stray_b && $urandom_range(3) == 0) begin
      dn_b <= 1'b1; om_b <= $urandom;
    end
  end

  // Event monitors
  int smul_cnt_a = 0, done_cnt_a = 0, smul_cnt_b = 0, done_cnt_b = 0;
  int rd_cnt_b = 0, seq_bad_b = 0, exp_addr_b = 229;
  always @(posedge clk) begin
    if (smul_a) smul_cnt_a <= smul_cnt_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (smul_b) smul_cnt_b <= smul_cnt_b + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (rd_b) begin
      if (int'(addr_b) != exp_addr_b) seq_bad_b <= seq_bad_b + 1;
      exp_addr_b <= exp_addr_b - 1;
      rd_cnt_b   <= rd_cnt_b + 1;
    end
  end

`ifdef POLY_EVAL_LEADING_SKIP_EN
  localparam int MULS_A = 3;
  localparam int MULS_B = 687;
`else
  localparam int MULS_A = 6;
  localparam int MULS_B = 690;
`endif

  task automatic wait_done_a(input int bound, output bit to);
    to = 1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_a) begin to = 0; break; end
    end
    @(negedge clk);
  endtask

  task automatic wait_done_b(input int bound, output bit to);
    to = 1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_b) begin to = 0; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if ({busy_a, done_a, rd_a, smul_a, busy_b, done_b, rd_b, smul_b} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000000", {busy_a, done_a, rd_a, smul_a, busy_b, done_b, rd_b, smul_b});
    end
    checks++;
    if (eval_a !== '0 || eval_b !== '0) begin
      errors++; $display("FAIL reset_eval got %h/%h exp 0", eval_a, eval_b);
    end
  endtask

  task automatic test_small;
    bit to;
    mem_a[1] = 8'h01; mem_a[0] = 8'h05;
    r_a = {3{32'h0000_0002}};
    smul_cnt_a = 0; done_cnt_a = 0;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    r_a = {32'hdead_beef, 32'h1234_5678, 32'hffff_ffff};
    wait_done_a(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL small_timeout got timeout exp done"); end
    for (int s = 0; s < T; s++) begin
      checks++;
      if (eval_a[32*s +: 32] !== 32'h0000_0007) begin
        errors++; $display("FAIL small_eval%0d got %h exp 00000007", s, eval_a[32*s +: 32]);
      end
    end
    checks++;
    if (done_cnt_a !== 1) begin errors++; $display("FAIL small_done_cnt got %0d exp 1", done_cnt_a); end
    checks++;
    if (smul_cnt_a !== MULS_A) begin errors++; $display("FAIL small_muls got %0d exp %0d", smul_cnt_a, MULS_A); end
  endtask

  task automatic test_zero;
    bit to;
    for (int i = 0; i < 230; i++) mem_b[i] = 8'h00;
    r_b = {$urandom, $urandom, $urandom};
    lat_b = 1; stray_b = 0;
    smul_cnt_b = 0; done_cnt_b = 0; rd_cnt_b = 0; seq_bad_b = 0; exp_addr_b = 229;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    wait_done_b(20000, to);
    checks++;
    if (to) begin errors++; $display("FAIL zero_timeout got timeout exp done"); end
    checks++;
    if (eval_b !== '0) begin errors++; $display("FAIL zero_eval got %h exp 0", eval_b); end
    checks++;
    if (smul_cnt_b !== MULS_B) begin errors++; $display("FAIL zero_muls got %0d exp %0d", smul_cnt_b, MULS_B); end
    checks++;
    if (rd_cnt_b !== 230 || seq_bad_b !== 0) begin
      errors++; $display("FAIL zero_reads got %0d reads %0d bad exp 230 reads 0 bad", rd_cnt_b, seq_bad_b);
    end
  endtask

  task automatic test_latency;
    bit to;
    logic [32*T-1:0] first;
    logic [31:0] x0, h2;
    x0 = '0; h2 = '0;
    for (int i = 0; i < 230; i++) begin
      mem_b[i] = 8'((i * 7 + 3) & 8'hff);
      x0 = x0 ^ {24'h0, mem_b[i]};
    end
    for (int i = 229; i >= 0; i--) h2 = gfmul(h2, 32'h1234_5678) ^ {24'h0, mem_b[i]};
    r_b = {32'h1234_5678, 32'h0000_0000, 32'h0000_0001};
    lat_b = 1; stray_b = 0;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    wait_done_b(20000, to);
    first = eval_b;
    checks++;
    if (to) begin errors++; $display("FAIL lat1_timeout got timeout exp done"); end
    checks++;
    if (first !== {h2, 24'h0, mem_b[0], x0}) begin
      errors++; $display("FAIL lat1_eval got %h exp %h", first, {h2, 24'h0, mem_b[0], x0});
    end
    lat_b = 5; stray_b = 1;
    rd_cnt_b = 0; seq_bad_b = 0; exp_addr_b = 229; done_cnt_b = 0;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    wait_done_b(20000, to);
    stray_b = 0;
    checks++;
    if (to) begin errors++; $display("FAIL lat5_timeout got timeout exp done"); end
    checks++;
    if (eval_b !== first) begin errors++; $display("FAIL lat5_eval got %h exp %h", eval_b, first); end
    checks++;
    if (rd_cnt_b !== 230 || seq_bad_b !== 0 || done_cnt_b !== 1) begin
      errors++; $display("FAIL lat5_seq got %0d reads %0d bad %0d done exp 230 0 1", rd_cnt_b, seq_bad_b, done_cnt_b);
    end
  endtask

  task automatic test_restart;
    bit to;
    r_a = {3{32'h0000_0002}};
    lat_a = 3; done_cnt_a = 0;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (5) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    to = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_a) begin to = 0; break; end
    end
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (to) begin errors++; $display("FAIL restart_timeout got timeout exp done"); end
    checks++;
    if (busy_a !== 1'b0 || done_cnt_a !== 1) begin
      errors++; $display("FAIL restart_state got busy %b done %0d exp busy 0 done 1", busy_a, done_cnt_a);
    end
    checks++;
    if (eval_a !== {3{32'h0000_0007}}) begin errors++; $display("FAIL restart_eval got %h exp 7s", eval_a); end
  endtask

  task automatic test_reset_midrun;
    bit to;
    lat_a = 5; done_cnt_a = 0;
    r_a = {3{32'h0000_0002}};
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    to = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (smul_a) begin to = 0; break; end
    end
    @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL rstmid_timeout got timeout exp mul start"); end
    checks++;
    if ({busy_a, done_a, rd_a, smul_a} !== 4'h0 || addr_a !== '0 || x_a !== '0 || y_a !== '0) begin
      errors++; $display("FAIL rstmid_outs got %b %h %h %h exp all 0", {busy_a, done_a, rd_a, smul_a}, addr_a, x_a, y_a);
    end
    checks++;
    if (eval_a !== '0) begin errors++; $display("FAIL rstmid_eval got %h exp 0", eval_a); end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt_a !== 0) begin errors++; $display("FAIL rstmid_done got %0d exp 0", done_cnt_a); end
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_done_a(300, to);
    checks++;
    if (to || eval_a !== {3{32'h0000_0007}}) begin
      errors++; $display("FAIL rstmid_rerun got %h exp 7s", eval_a);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_small;
    test_zero;
    test_latency;
    test_restart;
    test_reset_midrun;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
